mhd_error_sequencer: RTL and testbench
======================================

Name: mhd_error_sequencer

Overview:
- Sequential controller that streams (exact, approximate) output word pairs through a Hamming-distance threshold check.
- Accumulates error statistics over a programmed number of samples.
- Sits between the pattern/simulation source and the host that evaluates an approximate circuit against the maximum-Hamming-distance bound.
- Counts samples whose bitwise distance exceeds MHD, tracks the worst distance and the index of the first violation, and signals completion.

Parameters:
- WIDTH, 8: word width of compared outputs.
- MHD, 3: maximum allowed Hamming distance. A sample violates when dist > MHD.
- CNT_W, 16: width of the sample and error counters.
- DW, $clog2(WIDTH+1): distance width (4 for WIDTH=8). This is a derived localparam, not user-set.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle run request. Only sampled in IDLE or DONE.
- num_samples  in  CNT_W  samples per run. Latched on accepted start.
- in_valid  in  1  input pair valid.
- in_ready  out  1  block accepts pair this cycle.
- in_a  in  WIDTH  exact output word.
- in_b  in  WIDTH  approximate output word.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE state (level).
- err_count  out  CNT_W  number of violating samples. Saturates at all-ones.
- max_dist  out  DW  largest distance seen this run.
- first_err_idx  out  CNT_W  0-based index of first violating sample. All-ones if none.
- fail  out  1  high if err_count != 0.

Behaviour:
- Reset (async, any time incl. mid-run):
  - State goes to IDLE and both pipeline valid bits clear.
  - in_ready, busy, done, fail = 0; err_count = 0; max_dist = 0; first_err_idx = all-ones.
  - All internal counters = 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE, start=1:
  - Latch num_samples.
  - Clear err_count, max_dist, accepted count, retired count; first_err_idx goes to all-ones; done falls.
  - If num_samples == 0, go to DONE next cycle with cleared statistics. Otherwise go to RUN.
- RUN:
  - in_ready = 1 while accepted < num_samples_latched.
  - A transfer occurs when in_valid && in_ready; accepted increments on each transfer.
  - When the final transfer occurs, go to DRAIN next cycle. in_ready is 0 from that cycle on.
  - in_valid while in_ready=0 is ignored; no data is captured.
- Pipeline, 2 stages, no backpressure inside:
  - S1 registers diff = in_a ^ in_b with a valid bit and the sample index.
  - S2 registers dist = popcount(diff) (DW bits) and viol = (dist > MHD), with valid and index.
  - Statistics update on the cycle after S2 is valid. A pair accepted at edge t is reflected in the outputs after edge t+3.
- Statistics update, when S2 valid:
  - retired increments.
  - If viol: err_count increments (saturating at 2^CNT_W-1). If first_err_idx is all-ones, it is set to the S2 index.
  - max_dist = max(max_dist, dist).
  - fail is combinational from err_count != 0.
- DRAIN: stay until retired == num_samples_latched and the pipeline is empty, then go to DONE.
- DONE:
  - done = 1 and outputs hold until the next start.
  - start in DONE restarts the run, and done drops the next cycle.
- start while busy is ignored; latched num_samples is unaffected.
- Boundaries:
  - dist == MHD is not a violation.
  - dist == WIDTH (all bits differ) is legal, max_dist = WIDTH.
  - in_valid gaps in RUN stall the sequence indefinitely with no timeout.
  - Index counter width is CNT_W, so num_samples = 2^CNT_W-1 is the maximum run.

Test Plan:
- Reset behaviour: assert rst mid-RUN after 3 of 10 samples -> all outputs return to reset values immediately. A new start with 2 samples completes normally.
- Threshold edges: WIDTH=8, MHD=3, num_samples=4, pairs (00,07), (00,0F), (FF,00), (AA,AA) -> distances 3,4,8,0. Expected err_count=2, first_err_idx=1, max_dist=8, fail=1, done after 4th retire.
- Zero-length run: start with num_samples=0 -> DONE one cycle later, err_count=0, max_dist=0, first_err_idx=FFFF, fail=0, in_ready never high.
- Stalls and extra inputs: num_samples=3 with in_valid toggled 1,0,0,1,0,1 -> exactly 3 transfers. The extra in_valid after the 3rd transfer sees in_ready=0, and results are unaffected.
- Latency: single sample (0F,00) accepted at edge t -> err_count=1 visible after edge t+3, busy falls, done rises at DONE entry.
- Saturation and restart: CNT_W=4, 15 all-violating samples -> err_count=15. Start in DONE clears stats and done drops the next cycle. start pulsed during RUN is ignored.

Source files
------------

// File: rtl/mhd_error_sequencer.sv
// mhd_error_sequencer: streams (exact, approximate) word pairs through a
// Hamming-distance check against MHD and accumulates per-run statistics:
// violation count (saturating), worst distance and first violating index.
module mhd_error_sequencer #(
    parameter int WIDTH = 8,
    parameter int MHD   = 3,
    parameter int CNT_W = 16,
    localparam int DW   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_count,
    output logic [DW-1:0]    max_dist,
    output logic [CNT_W-1:0] first_err_idx,
    output logic             fail
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [CNT_W-1:0] ALL_ONES = '1;

    state_t           state, state_nx;
    logic [CNT_W-1:0] n_lat, accepted, retired;
    logic             start_ok, xfer, last_xfer, pipe_empty;

    // S1: raw difference; S2: distance and verdict; ret: commit register.
    logic             s1_valid, s2_valid, ret_valid;
    logic [WIDTH-1:0] s1_diff;
    logic [CNT_W-1:0] s1_idx, s2_idx, ret_idx;
    logic [DW-1:0]    s1_pop, s2_dist, ret_dist;
    logic             s2_viol, ret_viol;

    // Population count of the S1 difference word
    always_comb begin
        // NOTE: blocking '=' in combinational logic so the running sum is
        // visible to the next loop iteration within the same evaluation.
        s1_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s1_pop = s1_pop + DW'(s1_diff[i]);
        end
    end

    // Handshake, next-state and status decode
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would infer a latch.
        state_nx   = state;
        start_ok   = start && ((state == IDLE) || (state == DONE));
        in_ready   = (state == RUN) && (accepted < n_lat);
        xfer       = in_valid && in_ready;
        last_xfer  = xfer && ((accepted + CNT_W'(1)) == n_lat);
        pipe_empty = !s1_valid && !s2_valid && !ret_valid;
        unique case (state)
            IDLE, DONE: begin
                if (start_ok) begin
                    state_nx = (num_samples == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_xfer) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if ((retired == n_lat) && pipe_empty) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
        busy = (state == RUN) || (state == DRAIN);
        done = (state == DONE);
        fail = (err_count != '0);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking '<=' for all sequential state so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Pipeline valid bits: the only pipeline flops that need a reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            ret_valid <= 1'b0;
        end else begin
            s1_valid  <= xfer;
            s2_valid  <= s1_valid;
            ret_valid <= s2_valid;
        end
    end

    // Pipeline data path, qualified by the valid bits above
    always_ff @(posedge clk) begin
        // NOTE: data flops carry no reset; their contents are ignored until
        // the matching valid bit is set, so resetting them buys nothing.
        if (xfer) begin
            s1_diff <= in_a ^ in_b;
            s1_idx  <= accepted;
        end
        s2_dist  <= s1_pop;
        s2_viol  <= (s1_pop > DW'(MHD));
        s2_idx   <= s1_idx;
        ret_dist <= s2_dist;
        ret_viol <= s2_viol;
        ret_idx  <= s2_idx;
    end

    // Run bookkeeping and statistics accumulation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_lat         <= '0;
            accepted      <= '0;
            retired       <= '0;
            err_count     <= '0;
            max_dist      <= '0;
            first_err_idx <= ALL_ONES;
        end else if (start_ok) begin
            n_lat         <= num_samples;
            accepted      <= '0;
            retired       <= '0;
            err_count     <= '0;
            max_dist      <= '0;
            first_err_idx <= ALL_ONES;
        end else begin
            if (xfer) begin
                accepted <= accepted + CNT_W'(1);
            end
            if (ret_valid) begin
                retired <= retired + CNT_W'(1);
                if (ret_viol) begin
                    if (err_count != ALL_ONES) begin
                        err_count <= err_count + CNT_W'(1);
                    end
                    if (first_err_idx == ALL_ONES) begin
                        first_err_idx <= ret_idx;
                    end
                end
                if (ret_dist > max_dist) begin
                    max_dist <= ret_dist;
                end
            end
        end
    end

endmodule

// File: tb/tb_mhd_error_sequencer.sv
// Self-checking bench for mhd_error_sequencer (WIDTH=8, MHD=3, CNT_W=4).
// Accepted pairs are recorded in queues; expected statistics are computed
// from those queues with plain bit counting at the end of each run.
module tb_mhd_error_sequencer;

    localparam int WIDTH = 8;
    localparam int MHD   = 3;
    localparam int CNT_W = 4;
    localparam int DW    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] NONE = '1;

    logic             clk, rst, start, in_valid, in_ready;
    logic [CNT_W-1:0] num_samples;
    logic [WIDTH-1:0] in_a, in_b;
    logic             busy, done, fail;
    logic [CNT_W-1:0] err_count, first_err_idx;
    logic [DW-1:0]    max_dist;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] qa[$];
    logic [WIDTH-1:0] qb[$];
    logic [WIDTH-1:0] fa[16];
    logic [WIDTH-1:0] fb[16];

    mhd_error_sequencer #(.WIDTH(WIDTH), .MHD(MHD), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .busy(busy), .done(done), .err_count(err_count), .max_dist(max_dist),
        .first_err_idx(first_err_idx), .fail(fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int popc(input logic [WIDTH-1:0] x);
        int c = 0;
        for (int i = 0; i < WIDTH; i++) c += int'(x[i]);
        return c;
    endfunction

    // Pulse start for one cycle; return at the negedge after the start edge.
    task automatic start_run(input int n);
        @(negedge clk);
        start = 1'b1;
        num_samples = CNT_W'(n);
        @(negedge clk);
        start = 1'b0;
        num_samples = CNT_W'($urandom);
        check("start_err_clr", err_count, 0);
        check("start_max_clr", max_dist, 0);
        check("start_first_clr", first_err_idx, NONE);
        check("start_done", done, (n == 0));
        check("start_busy", busy, (n != 0));
    endtask

    // Offer pairs until n are taken plus two extra offered cycles.
    task automatic feed(input int n, input bit use_pat, input logic [31:0] pat,
                        input bit use_fixed, input int glitch);
        int cyc = 0;
        int extra = 0;
        int dut_x = 0;
        bit v, was_full;
        logic [WIDTH-1:0] a, b, m;
        qa.delete();
        qb.delete();
        while (extra < 2 && cyc < 400) begin
            was_full = (qa.size() == n);
            if (use_pat) v = pat[cyc % 32];
            else v = was_full ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (use_fixed && !was_full) begin
                a = fa[qa.size()];
                b = fb[qa.size()];
            end else begin
                a = WIDTH'($urandom);
                case ($urandom_range(0, 3))
                    0: m = '0;
                    1: m = WIDTH'($urandom & $urandom & $urandom);
                    2: m = WIDTH'($urandom & $urandom);
                    default: m = WIDTH'($urandom);
                endcase
                b = a ^ m;
            end
            in_valid = v;
            in_a = a;
            in_b = b;
            start = (cyc == glitch);
            if (cyc == glitch) num_samples = CNT_W'(n + 1);
            check("in_ready", in_ready, !was_full);
            if (in_ready && v) dut_x++;
            @(posedge clk);
            if (v && !was_full) begin
                qa.push_back(a);
                qb.push_back(b);
            end
            @(negedge clk);
            start = 1'b0;
            if (was_full) extra++;
            cyc++;
        end
        in_valid = 1'b0;
        check("feed_budget", (cyc < 400), 1);
        check("transfers", dut_x, n);
    endtask

    // Wait for DONE (bounded) and compare against the model of the queues.
    task automatic finish_run();
        int w = 0;
        int errs = 0;
        int first = int'(NONE);
        int maxd = 0;
        int d;
        for (int i = 0; i < qa.size(); i++) begin
            d = popc(qa[i] ^ qb[i]);
            if (d > MHD) begin
                if (errs < (1 << CNT_W) - 1) errs++;
                if (first == int'(NONE)) first = i;
            end
            if (d > maxd) maxd = d;
        end
        while (!done && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("done_wait", (w < 40), 1);
        check("err_count", err_count, errs);
        check("max_dist", max_dist, maxd);
        check("first_err_idx", first_err_idx, first);
        check("fail", fail, (errs != 0));
        check("busy_end", busy, 0);
        check("ready_end", in_ready, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        num_samples = '0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fail", fail, 0);
        check("rst_err", err_count, 0);
        check("rst_max", max_dist, 0);
        check("rst_first", first_err_idx, NONE);
        rst = 1'b0;

        // Reset in the middle of a 10-sample run after 3 violating samples.
        start_run(10);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a = 8'h00;
            in_b = 8'hFF;
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_err", err_count, 3);
        check("mid_ready", in_ready, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_ready", in_ready, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_fail", fail, 0);
        check("arst_err", err_count, 0);
        check("arst_max", max_dist, 0);
        check("arst_first", first_err_idx, NONE);
        @(negedge clk);
        rst = 1'b0;
        start_run(2);
        feed(2, 1'b0, 32'h0, 1'b0, -1);
        finish_run();

        // Threshold edges: distances 3, 4, 8, 0.
        fa[0] = 8'h00; fb[0] = 8'h07;
        fa[1] = 8'h00; fb[1] = 8'h0F;
        fa[2] = 8'hFF; fb[2] = 8'h00;
        fa[3] = 8'hAA; fb[3] = 8'hAA;
        start_run(4);
        feed(4, 1'b1, 32'hFFFF_FFFF, 1'b1, -1);
        finish_run();

        // Zero-length run straight out of DONE with nonzero statistics.
        start_run(0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            check("zero_ready", in_ready, 0);
            check("zero_done", done, 1);
            check("zero_fail", fail, 0);
        end
        in_valid = 1'b0;

        // Stalls and extra valids: pattern 1,0,0,1,0,1 then 1,1.
        start_run(3);
        feed(3, 1'b1, 32'h0000_00E9, 1'b0, -1);
        finish_run();

        // Latency of a single violating sample.
        start_run(1);
        in_valid = 1'b1;
        in_a = 8'h0F;
        in_b = 8'h00;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("lat_t0", err_count, 0);
        @(negedge clk);
        check("lat_t1", err_count, 0);
        @(negedge clk);
        check("lat_t2", err_count, 0);
        @(negedge clk);
        check("lat_t3", err_count, 1);
        check("lat_t3_busy", busy, 1);
        check("lat_t3_done", done, 0);
        @(negedge clk);
        check("lat_t4_done", done, 1);
        check("lat_t4_busy", busy, 0);
        check("lat_max", max_dist, 4);
        check("lat_first", first_err_idx, 0);

        // Fifteen violating samples, restarted from DONE, start pulsed in RUN.
        for (int i = 0; i < 15; i++) begin
            fa[i] = 8'h00;
            fb[i] = 8'hFF;
        end
        start_run(15);
        feed(15, 1'b0, 32'h0, 1'b1, 3);
        finish_run();

        // Randomized runs.
        for (int r = 0; r < 8; r++) begin
            int n = $urandom_range(1, 15);
            start_run(n);
            feed(n, 1'b0, 32'h0, 1'b0, (r % 2 == 0) ? int'($urandom_range(0, 4)) : -1);
            finish_run();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
